rf_wb_scheduler: RTL and testbench
==================================

RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 The block SHALL have parameter INIT_VALUE, default 32'h0000_0000: the data written to x1..x31 during the init sweep.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15: the maximum number of consecutive req0 grants while req1_valid is high.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid input 1, req0_rd input 5, req0_wd input 32: the primary (pipeline writeback) request.
REQ-006 The block SHALL have port req0_ready, output, 1: req0 is accepted at the next edge when req0_valid is also high.
REQ-007 The block SHALL have ports req1_valid input 1, req1_rd input 5, req1_wd input 32, req1_ready output 1: the secondary (multi-cycle unit) request, with the same semantics as req0.
REQ-008 The block SHALL have ports rf_we output 1, rf_rd output 5, rf_wd output 32: the register-file write port (we, rd, wd).
REQ-009 The block SHALL have port init_done, output, 1: high once the init sweep is complete.

Function
REQ-010 The block SHALL have two states: INIT (sweep) and RUN.
REQ-011 rf_we, rf_rd and rf_wd SHALL be registered outputs; req0_ready and req1_ready SHALL be combinational from state, starve_cnt and the opposing valid only, with no path from a requester's own valid to its own ready.
REQ-012 INIT sweep: the first edge after rst_n rises SHALL load rf_we=1, rf_rd=1, rf_wd=INIT_VALUE.
REQ-013 On each following edge in INIT, rf_rd SHALL increment by 1, so x1..x31 are each written exactly once over 31 consecutive cycles.
REQ-014 The edge after the rf_rd=31 cycle SHALL clear rf_we, set init_done=1 and enter RUN.
REQ-015 In INIT, req0_ready and req1_ready SHALL be 0.
REQ-016 In RUN, req0_ready SHALL equal (!req1_valid | starve_cnt<STARVE_LIMIT).
REQ-017 In RUN, req1_ready SHALL equal (!req0_valid | starve_cnt==STARVE_LIMIT).
REQ-018 At most one request SHALL be accepted per edge, and req0_ready and req1_ready SHALL never both be high while both valids are high.
REQ-019 Accept latency: a request accepted at edge N SHALL drive rf_we=1 and its rd/wd during the cycle after edge N, for exactly one cycle unless another accept occurs at edge N+1.
REQ-020 Back-to-back accepts SHALL give sustained throughput of 1 write per cycle.
REQ-021 A request with rd=0 SHALL be accepted normally but SHALL produce rf_we=0 in its write cycle, with rf_rd and rf_wd still updated.
REQ-022 The 4-bit counter starve_cnt SHALL update as follows:
- +1 on a req0 accept while req1_valid=1;
- cleared on a req1 accept;
- cleared on any edge with req1_valid=0;
- saturating at STARVE_LIMIT.
REQ-023 A cycle in RUN with no accept SHALL set rf_we=0 at the next edge, leaving rf_rd and rf_wd holding their last values.
REQ-024 Requesters SHALL hold rd/wd stable while valid=1 and ready=0; the block SHALL sample payload only on accept.
REQ-025 init_done SHALL remain 1 until the next reset.

Reset
REQ-026 While rst_n=0, all of the following SHALL be 0, asynchronously: rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready, starve_cnt; the state SHALL be INIT with sweep index 0.
REQ-027 Reset asserted mid-sweep or mid-RUN SHALL abort immediately, discard any pending write, and restart the full sweep from x1 after release.

Verification
REQ-028 Release reset, no requests -> rf_we high on cycles 1..31 with rf_rd=1..31 and rf_wd=INIT_VALUE; init_done=1 from cycle 32; both ready=0 before cycle 32.
REQ-029 RUN, req0 only, rd=5, wd=32'hDEADBEEF, held 3 cycles -> three accepts; rf_we=1 with rf_rd=5 for 3 consecutive cycles, each starting one cycle after its accept.
REQ-030 RUN, both valid continuously, STARVE_LIMIT=4 -> grant pattern req0,req0,req0,req0,req1 repeating; rf_rd alternates per payload; never two readies at once.
REQ-031 RUN, req1 only, rd=0, wd=32'h1234 -> accepted; rf_we stays 0; rf_rd=0 in write cycle.
REQ-032 Assert rst_n=0 at sweep cycle 10, hold 2 cycles, release -> outputs 0 immediately; sweep restarts at rf_rd=1; init_done rises 32 cycles after release.
REQ-033 req0 valid, req1 toggling valid every other cycle -> starve_cnt clears whenever req1_valid=0; req1 is granted only when req0_valid=0 or starve_cnt reaches 4.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file writeback scheduler: x1..x31 init sweep, then two-requester arbitration
module rf_wb_scheduler #(
  parameter logic [31:0] INIT_VALUE   = 32'h0000_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_wd,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_wd,
  output logic        req1_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        init_done
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       acc0;
  logic       acc1;

  // Each ready looks only at the opposing valid, so a requester never waits on itself.
  assign req0_ready = (state == RUN) && (!req1_valid || (starve_cnt < LIMIT));
  assign req1_ready = (state == RUN) && (!req0_valid || (starve_cnt == LIMIT));
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      starve_cnt <= 4'd0;
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_wd      <= 32'd0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          // rf_rd doubles as the sweep index; it is 0 only before the first sweep edge.
          if (rf_we && (rf_rd == 5'd31)) begin
            rf_we     <= 1'b0;
            init_done <= 1'b1;
            state     <= RUN;
          end else begin
            rf_we <= 1'b1;
            rf_rd <= rf_rd + 5'd1;
            rf_wd <= INIT_VALUE;
          end
        end
        RUN: begin
          if (acc1) begin
            rf_we <= (req1_rd != 5'd0);
            rf_rd <= req1_rd;
            rf_wd <= req1_wd;
          end else if (acc0) begin
            rf_we <= (req0_rd != 5'd0);
            rf_rd <= req0_rd;
            rf_wd <= req0_wd;
          end else begin
            rf_we <= 1'b0;
          end

          if (!req1_valid || acc1) begin
            starve_cnt <= 4'd0;
          end else if (acc0 && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;

  localparam logic [31:0] INIT_VAL = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_rd = 5'd0;
  logic [31:0] req0_wd = 32'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_rd = 5'd0;
  logic [31:0] req1_wd = 32'd0;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        init_done;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_scheduler #(.INIT_VALUE(INIT_VAL), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_rd    (req0_rd),
    .req0_wd    (req0_wd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rd    (req1_rd),
    .req1_wd    (req1_wd),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%b rd=%0d wd=%h done=%b r0=%b r1=%b, want all 0",
               rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep(input int n, input bit finish);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready} !== {1'b1, 5'(k), INIT_VAL, 3'b000}) begin
        n_fail++;
        $display("FAIL sweep_cycle_%0d: got we=%b rd=%0d wd=%h done=%b r0=%b r1=%b, want we=1 rd=%0d wd=%h done=0 r0=0 r1=0",
                 k, rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready, k, INIT_VAL);
      end
    end
    if (finish) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready} !== {1'b0, 5'd31, INIT_VAL, 3'b111}) begin
        n_fail++;
        $display("FAIL sweep_done: got we=%b rd=%0d wd=%h done=%b r0=%b r1=%b, want we=0 rd=31 done=1 r0=1 r1=1",
                 rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready);
      end
    end
  endtask

  task automatic test_req0_only();
    req0_valid = 1'b1;
    req0_rd    = 5'd5;
    req0_wd    = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({rf_we, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL req0_pre: got we=%b ready0=%b, want we=0 ready0=1", rf_we, req0_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
        n_fail++;
        $display("FAIL req0_write_%0d: got we=%b rd=%0d wd=%h, want we=1 rd=5 wd=deadbeef", i, rf_we, rf_rd, rf_wd);
      end
    end
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rf_we, rf_rd, rf_wd, init_done} !== {1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL req0_idle: got we=%b rd=%0d wd=%h done=%b, want we=0 rd=5 wd=deadbeef done=1",
               rf_we, rf_rd, rf_wd, init_done);
    end
  endtask

  task automatic test_back_to_back();
    logic g;
    req0_valid = 1'b1; req0_rd = 5'd2; req0_wd = 32'h0000_0022;
    req1_valid = 1'b1; req1_rd = 5'd3; req1_wd = 32'h0000_0033;
    for (int i = 0; i < 10; i++) begin
      g = (i % 5 == 4);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== {!g, g}) begin
        n_fail++;
        $display("FAIL arb_ready_%0d: got r0=%b r1=%b, want r0=%b r1=%b", i, req0_ready, req1_ready, !g, g);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({rf_we, rf_rd, rf_wd} !== (g ? {1'b1, 5'd3, 32'h33} : {1'b1, 5'd2, 32'h22})) begin
        n_fail++;
        $display("FAIL arb_write_%0d: got we=%b rd=%0d wd=%h, want rd=%0d", i, rf_we, rf_rd, rf_wd, g ? 3 : 2);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_rd_zero();
    req1_valid = 1'b1; req1_rd = 5'd0; req1_wd = 32'h0000_1234;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd0_ready: got r1=%b, want 1", req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    n_checks++;
    if ({rf_we, rf_rd, rf_wd} !== {1'b0, 5'd0, 32'h0000_1234}) begin
      n_fail++;
      $display("FAIL rd0_write: got we=%b rd=%0d wd=%h, want we=0 rd=0 wd=1234", rf_we, rf_rd, rf_wd);
    end
  endtask

  task automatic test_starve_clear();
    logic g;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_wd = 32'h77;
    req1_rd = 5'd9; req1_wd = 32'h99;
    // req1 drops once at step 3, resetting the starvation count, so it only wins at step 8.
    for (int i = 0; i < 9; i++) begin
      req1_valid = (i != 3);
      g = (i == 8);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== {!g, g}) begin
        n_fail++;
        $display("FAIL starve_ready_%0d: got r0=%b r1=%b, want r0=%b r1=%b", i, req0_ready, req1_ready, !g, g);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (rf_rd !== (g ? 5'd9 : 5'd7)) begin
        n_fail++;
        $display("FAIL starve_write_%0d: got rd=%0d, want %0d", i, rf_rd, g ? 9 : 7);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_sweep(10, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rf_we, rf_rd, rf_wd, init_done, req0_ready, req1_ready} !== 41'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got we=%b rd=%0d wd=%h done=%b, want all 0", rf_we, rf_rd, rf_wd, init_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_sweep(31, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sweep(31, 1'b1);
    test_req0_only();
    test_back_to_back();
    test_rd_zero();
    test_starve_clear();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
